// File: rtl/alu_input_seq.sv
// -----------------------------------------------------------------------------
// alu_input_seq
//
// Operand/opcode entry sequencer for a switch-driven ALU demo. A single
// push-button ("step") walks the FSM through LOAD_A -> LOAD_B -> LOAD_OP ->
// EXEC -> SHOW. Each press latches the switch value for the current state.
// EXEC captures the downstream ALU result/flags, and SHOW presents them.
//
// Ports
//   CLK          in   1   system clock, rising edge
//   RST          in   1   asynchronous active-high reset
//   step         in   1   raw push-button level (asynchronous, pressed = 1)
//   sw_data      in  17   operand switches: bit 16 = sign, bits 15:0 = value
//   sw_op        in   4   ALU opcode switches
//   alu_out      in  32   result from the downstream ALU
//   alu_flags    in   3   {overflow, negative, zero} from the downstream ALU
//   a_out        out 32   operand A (sign-extended sw_data)
//   b_out        out 32   operand B (sign-extended sw_data)
//   op_out       out  4   opcode
//   result       out 32   captured ALU result
//   flags        out  3   captured {overflow, negative, zero}
//   result_valid out  1   result/flags hold a completed operation
//   state_out    out  3   LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4
//
// Configuration
//   ALU_SEQ_DEBOUNCE_EN  when defined, the synchronized button must hold a new
//                        level for DB_CYCLES consecutive cycles before the
//                        debounced level follows it. When undefined, the
//                        debounced level is the synchronized level, and
//                        DB_CYCLES is ignored.
// -----------------------------------------------------------------------------
package alu_input_seq_pkg;
  typedef logic [3:0] aluop_t;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;
endpackage

module alu_input_seq
  import alu_input_seq_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        step,
  input  logic [16:0] sw_data,
  input  aluop_t      sw_op,
  input  logic [31:0] alu_out,
  input  logic [2:0]  alu_flags,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output aluop_t      op_out,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic        result_valid,
  output logic [2:0]  state_out
);

  // ---------------------------------------------------------------------------
  // Button synchronizer
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce (optional)
  // ---------------------------------------------------------------------------
  logic w_db;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CntW-1:0] r_db_cnt;
  logic            r_db;

  // The count runs only while the synchronized level disagrees with the
  // debounced level. Any agreement resets the count, so only an unbroken
  // run of DB_CYCLES cycles moves the debounced level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db_cnt <= '0;
      r_db     <= 1'b0;
    end else if (r_sync2 != r_db) begin
      if (r_db_cnt == CntW'(DB_CYCLES - 1)) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  assign w_db = r_db;
`else
  assign w_db = r_sync2;
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge pulse with release arming
  // ---------------------------------------------------------------------------
  // r_seen marks when r_sync2 first holds a real sample of the button after
  // reset. The edge detector is armed only after such a sample shows the
  // button released. A button held through reset release therefore gives no
  // pulse until it is let go and pressed again.
  logic [1:0] r_seen;
  logic       r_armed;
  logic       r_db_q;
  logic       r_step_p;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seen   <= 2'b00;
      r_armed  <= 1'b0;
      r_db_q   <= 1'b0;
      r_step_p <= 1'b0;
    end else begin
      r_seen   <= {r_seen[0], 1'b1};
      r_armed  <= r_armed | (r_seen[1] & ~r_sync2);
      r_db_q   <= w_db;
      r_step_p <= w_db & ~r_db_q & r_armed;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  aluop_t      r_op;
  logic [31:0] r_result;
  logic [2:0]  r_flags;
  logic        r_valid;

  logic [31:0] w_sx_data;
  assign w_sx_data = {{15{sw_data[16]}}, sw_data};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= LOAD_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (r_step_p) begin
            r_a     <= w_sx_data;
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (r_step_p) begin
            r_b     <= w_sx_data;
            r_state <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (r_step_p) begin
            r_op    <= sw_op;
            r_state <= EXEC;
          end
        end
        // The ALU sees the new op_out during EXEC, so its output is sampled
        // on the EXEC->SHOW edge.
        EXEC: begin
          r_result <= alu_out;
          r_flags  <= alu_flags;
          r_valid  <= 1'b1;
          r_state  <= SHOW;
        end
        SHOW: begin
          if (r_step_p) begin
            r_valid <= 1'b0;
            r_state <= LOAD_A;
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign a_out        = r_a;
  assign b_out        = r_b;
  assign op_out       = r_op;
  assign result       = r_result;
  assign flags        = r_flags;
  assign result_valid = r_valid;
  assign state_out    = r_state;

endmodule

// File: doc/alu_input_seq.md
ALU_INPUT_SEQ -- requirements
Module: alu_input_seq

Interface
REQ-001 Parameter: DB_CYCLES, default 16, number of consecutive stable cycles required to accept a step-level change (range 2..2^20).
REQ-002 Port: CLK  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: RST  in  1  asynchronous, active-high reset.
REQ-004 Port: step  in  1  raw push-button level, asynchronous to CLK, pressed = 1.
REQ-005 Port: sw_data  in  17  operand switches; bit 16 = sign, bits 15:0 = value.
REQ-006 Port: sw_op  in  4  ALU opcode switches, passed through unmodified as aluop_t.
REQ-007 Port: alu_out  in  32  ALU result from the downstream ALU.
REQ-008 Port: alu_flags  in  3  {overflow, negative, zero} from the downstream ALU.
REQ-009 Port: a_out  out  32  registered operand A to ALU.
REQ-010 Port: b_out  out  32  registered operand B to ALU.
REQ-011 Port: op_out  out  4  registered opcode to ALU.
REQ-012 Port: result  out  32  captured ALU result.
REQ-013 Port: flags  out  3  captured {overflow, negative, zero}.
REQ-014 Port: result_valid  out  1  high while result/flags hold a completed operation.
REQ-015 Port: state_out  out  3  current state encoding (LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4).

Function
REQ-016 step SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 The debounced level SHALL change only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any reversion restarts the count at 0.
REQ-018 A single-cycle step_p pulse SHALL be generated on each 0->1 transition of the debounced level; a held button SHALL produce exactly one pulse.
REQ-019 FSM: LOAD_A --step_p--> LOAD_B --step_p--> LOAD_OP --step_p--> EXEC --(unconditional, 1 cycle)--> SHOW --step_p--> LOAD_A; with no step_p, LOAD_A/LOAD_B/LOAD_OP/SHOW SHALL hold.
REQ-020 On step_p in LOAD_A, a_out SHALL load {{15{sw_data[16]}}, sw_data[16], sw_data[15:0]} i.e. 32-bit sign extension of bit 16 over bits 31:16.
REQ-021 On step_p in LOAD_B, b_out SHALL load the same sign-extended value; a_out unchanged.
REQ-022 On step_p in LOAD_OP, op_out SHALL load sw_op.
REQ-023 In EXEC, result and flags SHALL capture alu_out and alu_flags, and result_valid SHALL become 1 on the EXEC->SHOW edge; result_valid therefore rises 2 cycles after the step_p that left LOAD_OP.
REQ-024 result, flags, a_out, b_out, op_out SHALL hold between capture events, including across SHOW->LOAD_A.
REQ-025 result_valid SHALL clear on the SHOW->LOAD_A edge and SHALL not reassert until the next EXEC.
REQ-026 Switch changes outside a capturing step_p SHALL have no effect on any output.

Reset
REQ-027 While RST=1, state SHALL be LOAD_A and a_out, b_out, result SHALL be 0x00000000, op_out 4'h0, flags 3'b000, result_valid 0.
REQ-028 Synchronizer flops, debounced level and debounce counter SHALL reset to 0; a button held through reset release SHALL produce no step_p until released and pressed again.
REQ-029 Reset asserted mid-sequence (any state, including EXEC) SHALL abort immediately; no partial capture survives.

Configuration
REQ-030 Macro ALU_SEQ_DEBOUNCE_EN: when defined, REQ-017 debounce is compiled in; when undefined, the debounced level SHALL equal the synchronized level (no counter, DB_CYCLES ignored), step_p latency = 3 cycles from step rise.

Verification
REQ-031 Reset: RST pulse mid-LOAD_OP -> state_out=0, all outputs zero, result_valid=0 within same cycle as RST rise.
REQ-032 Full sequence: sw_data=0x00005 step, 0x1FFFD step, sw_op=4'h3 step; bench ALU returns 0x00000002/3'b000 -> a_out=0x00000005, b_out=0xFFFFFFFD, op_out=3, result=0x00000002, result_valid=1 two cycles after third step_p.
REQ-033 Debounce (macro on, DB_CYCLES=16): 10-cycle step glitch -> no step_p, state unchanged; 20-cycle press -> exactly one step_p.
REQ-034 Held step for 200 cycles in LOAD_A -> exactly one transition to LOAD_B.
REQ-035 SHOW, toggle switches, no step -> result/flags/a_out stable; then step -> LOAD_A, result_valid=0, result still 0x00000002.
REQ-036 Macro off: clean step rise -> step_p exactly 3 cycles later, single cycle wide.
